multiword_adder: RTL and testbench
==================================

Name: multiword_adder

Overview:
- Sequential multi-precision adder/subtractor that reuses a single cla_adder stage over several cycles.
- Operands of WIDTH*WORDS bits are split into WIDTH-bit chunks and fed to the CLA least-significant chunk first.
- The chunk carry-out is registered and fed back as the next chunk's carry-in.
- Sits directly upstream of the CLA: it feeds its operands and carry, and consumes its sum and carry-out; trades latency for area on wide datapath words.

Parameters:
- WIDTH, 4, chunk width in bits; passed to cla_adder width.
- WORDS, 4, number of chunks; total operand width N = WIDTH*WORDS; WORDS >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op_sub  input  1  0 = a+b+c_in, 1 = a-b (c_in ignored).
- c_in  input  1  carry into bit 0 for addition.
- a  input  N  operand A, latched on accepted start.
- b  input  N  operand B, latched on accepted start.
- busy  output  1  high while the operation is in progress (RUN and DONE).
- done  output  1  one-cycle pulse; result valid.
- sum  output  N  result; holds until the next accepted start.
- c_out  output  1  carry out of bit N-1 (for subtraction, 1 = no borrow).
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset: one clock; synchronous, active-high. Synchronous reset clears state to IDLE and busy, done, sum, c_out, overflow, zero, chunk index and carry register to 0. Reset mid-operation aborts it: no done pulse, and partial sum is cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch a_r = a and b_r = (op_sub ? ~b : b);
  - carry_r = (op_sub ? 1 : c_in);
  - idx = 0;
  - clear sum, c_out, overflow, zero;
  - go to RUN.
- IDLE, start=0: outputs hold.
- RUN, each cycle:
  - CLA inputs are a_r[idx], b_r[idx] and carry_r;
  - sum chunk idx <= CLA sum;
  - carry_r <= CLA c_out;
  - idx++.
  - When idx == WORDS-1, the transition goes to DONE.
- DONE, one cycle:
  - done = 1;
  - c_out = carry_r;
  - overflow = (a_r[N-1] == b_r[N-1]) && (sum[N-1] != a_r[N-1]);
  - zero = (sum == 0);
  - next state is IDLE.
- busy = 1 in RUN and DONE. The done pulse and flags become valid together. busy drops the cycle after done.
- Latency: start accepted at edge T gives done high in cycle T+WORDS+1 (after WORDS RUN cycles). Back-to-back: a new start is accepted the cycle after DONE.
- start while busy is ignored; operands are not re-latched and the current operation is unaffected.
- a and b may change freely after acceptance.
- op_sub with b = 0: ~0 + 1 wraps to 0 with c_out = 1.
- Arithmetic is modulo 2^N; carry/borrow is reported only on c_out.
- idx is ceil(log2(WORDS)) bits and never exceeds WORDS-1.

Decomposition:
- Shared datapath package holds the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH/WORDS constants.
- Exactly one sub-module: cla_adder, instantiated once with width = WIDTH, positional ports (a, b, c_in, c_out, sum).
- Chunk mux/demux and flag logic stay inline.

Test Plan (WIDTH=4, WORDS=4, N=16):
- a=0x0001, b=0x00FF, add, c_in=0: sum=0x0100, c_out=0, overflow=0, zero=0; done exactly 5 cycles after the start edge, busy high for 5 cycles.
- a=0xFFFF, b=0x0001, add: sum=0x0000, c_out=1, zero=1, overflow=0. Checks carry propagated through all 4 chunks.
- a=0x0005, b=0x0007, op_sub=1: sum=0xFFFE, c_out=0 (borrow), overflow=0. Then a=0x8000, b=0x0001, op_sub=1: sum=0x7FFF, overflow=1, c_out=1.
- a=0x7FFF, b=0x0001, add: sum=0x8000, overflow=1, c_out=0. Then a=0x00FF, b=0x0000, c_in=1: sum=0x0100.
- Start accepted; pulse start again with different operands in cycle 2 of RUN: it is ignored, the first result is delivered, and only one done pulse occurs.
- Assert rst during RUN (idx=2): next cycle busy=0, sum=0, no done. A start in the following cycle completes normally.

Source files
------------

// File: rtl/multiword_adder_pkg.sv
// Shared definitions for the chunk-serial multi-precision adder/subtractor.
// Holds the FSM state encoding and the default chunk geometry.
package multiword_adder_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_adder.sv
// Single-stage carry-lookahead adder. Each carry is formed as a flat
// generate/propagate sum of products rather than a ripple chain.
module cla_adder #(
    parameter int width = 4
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             c_in,
    output logic             c_out,
    output logic [width-1:0] sum
);

    logic [width-1:0] g;
    logic [width-1:0] p;
    logic [width:0]   carry;
    logic             acc;
    logic             term;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        carry    = '0;
        acc      = 1'b0;
        term     = 1'b0;
        carry[0] = c_in;
        for (int i = 0; i < width; i++) begin
            acc = c_in;
            for (int k = 0; k <= i; k++) begin
                acc = acc & p[k];
            end
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            carry[i+1] = acc;
        end
    end

    assign sum   = p ^ carry[width-1:0];
    assign c_out = carry[width];

endmodule

// File: rtl/multiword_adder.sv
// Multi-precision add/subtract that reuses one CLA chunk over WORDS cycles,
// least-significant chunk first, with the chunk carry registered between cycles.
//
// state | meaning
// IDLE  | waiting for start; result and flags hold
// RUN   | one chunk per cycle through the CLA
// DONE  | done pulse; result and flags valid
module multiword_adder
    import multiword_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     op_sub,
    input  logic                     c_in,
    input  logic [WIDTH*WORDS-1:0]   a,
    input  logic [WIDTH*WORDS-1:0]   b,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH*WORDS-1:0]   sum,
    output logic                     c_out,
    output logic                     overflow,
    output logic                     zero
);

    localparam int N     = WIDTH * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     a_r;
    logic [N-1:0]     b_r;
    logic [N-1:0]     sum_nxt;
    logic             carry_r;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_chunk;
    logic [WIDTH-1:0] b_chunk;
    logic [WIDTH-1:0] cla_sum;
    logic             cla_cout;
    logic             last;

    assign a_chunk = a_r[idx*WIDTH +: WIDTH];
    assign b_chunk = b_r[idx*WIDTH +: WIDTH];
    assign last    = (idx == LAST_IDX);

    cla_adder #(.width(WIDTH)) u_cla (a_chunk, b_chunk, carry_r, cla_cout, cla_sum);

    // Full result including the chunk being written, so the flags land with the last chunk.
    always_comb begin
        sum_nxt = sum;
        sum_nxt[idx*WIDTH +: WIDTH] = cla_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r      <= a;
                        b_r      <= op_sub ? ~b : b;
                        carry_r  <= op_sub ? 1'b1 : c_in;
                        idx      <= '0;
                        sum      <= '0;
                        c_out    <= 1'b0;
                        overflow <= 1'b0;
                        zero     <= 1'b0;
                    end
                end
                RUN: begin
                    sum     <= sum_nxt;
                    carry_r <= cla_cout;
                    if (last) begin
                        idx      <= '0;
                        c_out    <= cla_cout;
                        overflow <= (a_r[N-1] == b_r[N-1]) && (sum_nxt[N-1] != a_r[N-1]);
                        zero     <= (sum_nxt == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_adder.sv
// Scoreboard bench for multiword_adder (WIDTH=4, WORDS=4): stimulus pushes
// hand-computed results, a done-driven monitor pops and compares them.
module tb_multiword_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic        c_in = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        c_out;
    logic        overflow;
    logic        zero;

    multiword_adder #(.WIDTH(4), .WORDS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_sub   (op_sub),
        .c_in     (c_in),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        logic        c_out;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   done_count = 0;
    int   n_issued = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no pulse");
            end else begin
                mon_e = exp_q.pop_front();
                check("sum",      32'(sum),      32'(mon_e.sum));
                check("c_out",    32'(c_out),    32'(mon_e.c_out));
                check("overflow", 32'(overflow), 32'(mon_e.ovf));
                check("zero",     32'(zero),     32'(mon_e.zero));
            end
        end
    end

    // Called at a falling edge; returns at the first falling edge of RUN.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic sub,
                            input logic cin, input bit push, input logic [15:0] esum,
                            input logic ec, input logic eo, input logic ez);
        exp_t e;
        a      = av;
        b      = bv;
        op_sub = sub;
        c_in   = cin;
        start  = 1'b1;
        if (push) begin
            e.sum   = esum;
            e.c_out = ec;
            e.ovf   = eo;
            e.zero  = ez;
            exp_q.push_back(e);
            n_issued++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n, output int bc);
        n  = n0;
        bc = 0;
        while (n <= 20) begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1) break;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic sub,
                         input logic cin, input logic [15:0] esum,
                         input logic ec, input logic eo, input logic ez);
        int n;
        int bc;
        start_op(av, bv, sub, cin, 1'b1, esum, ec, eo, ez);
        wait_done(1, n, bc);
        check("latency", 32'(n), 32'd5);
        check("busy_cycles", 32'(bc), 32'd5);
        @(negedge clk);
        check("busy_drop", 32'(busy), 32'd0);
        check("sum_hold", 32'(sum), 32'(esum));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int bc;
        int d0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_ctrl", 32'({busy, done, c_out, overflow, zero}), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        rst = 1'b0;

        //     a         b         sub   cin   sum       c_out ovf   zero
        issue(16'h0001, 16'h00FF, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        issue(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        issue(16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        issue(16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0);
        issue(16'h4321, 16'h4321, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        issue(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0);
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

        // Second start during RUN must be ignored and must not re-latch operands.
        d0 = done_count;
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a      = 16'hAAAA;
        b      = 16'h5555;
        op_sub = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done(3, n, bc);
        check("ignored_start_latency", 32'(n), 32'd5);
        @(negedge clk);
        check("ignored_start_busy_drop", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("single_done", 32'(done_count - d0), 32'd1);

        // Reset while idx=2 aborts the operation with no done pulse.
        d0 = done_count;
        start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        check("abort_no_done", 32'(done_count - d0), 32'd0);
        issue(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_count), 32'(n_issued));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
